// File: rtl/engine_stream_switch_if.sv
// Bus bundle for engine_stream_switch: APB control port, the VDMA
// mm2s/s2mm stream pair and the per-engine stream channels.
interface engine_stream_switch_if #(
    parameter int NUM_ENG = 3,
    parameter int DATA_W  = 32
);
    // APB
    logic [31:0]             PADDR;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [31:0]             PWDATA;
    logic [31:0]             PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    // VDMA mm2s (into the switch)
    logic [DATA_W-1:0]       S_AXIS_TDATA;
    logic                    S_AXIS_TVALID;
    logic                    S_AXIS_TLAST;
    logic                    S_AXIS_TREADY;

    // VDMA s2mm (out of the switch)
    logic [DATA_W-1:0]       M_AXIS_TDATA;
    logic                    M_AXIS_TVALID;
    logic                    M_AXIS_TLAST;
    logic                    M_AXIS_TREADY;

    // Engine array, input side
    logic [NUM_ENG*DATA_W-1:0] ENG_S_TDATA;
    logic [NUM_ENG-1:0]      ENG_S_TVALID;
    logic [NUM_ENG-1:0]      ENG_S_TLAST;
    logic [NUM_ENG-1:0]      ENG_S_TREADY;

    // Engine array, output side
    logic [NUM_ENG*DATA_W-1:0] ENG_M_TDATA;
    logic [NUM_ENG-1:0]      ENG_M_TVALID;
    logic [NUM_ENG-1:0]      ENG_M_TLAST;
    logic [NUM_ENG-1:0]      ENG_M_TREADY;

    // The switch's view of the bundle
    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST,
        output S_AXIS_TREADY,
        output M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
        input  M_AXIS_TREADY,
        output ENG_S_TDATA, ENG_S_TVALID, ENG_S_TLAST,
        input  ENG_S_TREADY,
        input  ENG_M_TDATA, ENG_M_TVALID, ENG_M_TLAST,
        output ENG_M_TREADY
    );

    // The surrounding system's view (APB master, VDMA, engines)
    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST,
        input  S_AXIS_TREADY,
        input  M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
        output M_AXIS_TREADY,
        input  ENG_S_TDATA, ENG_S_TVALID, ENG_S_TLAST,
        output ENG_S_TREADY,
        output ENG_M_TDATA, ENG_M_TVALID, ENG_M_TLAST,
        input  ENG_M_TREADY
    );
endinterface

// File: rtl/engine_stream_switch.sv
// engine_stream_switch: routes one VDMA stream pair to one of NUM_ENG
// compute engines, selected over APB. Each job is beat-counted on both
// directions, checks incoming TLAST against the programmed length and
// reports busy/done/error status.
module engine_stream_switch #(
    parameter int NUM_ENG = 3,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 20
) (
    input logic                   CLK,
    input logic                   RESETN,
    engine_stream_switch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_IN_LEN  = 3'd1;
    localparam logic [2:0] A_OUT_LEN = 3'd2;
    localparam logic [2:0] A_STATUS  = 3'd3;
    localparam logic [2:0] A_IN_CNT  = 3'd4;
    localparam logic [2:0] A_OUT_CNT = 3'd5;

    state_e           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       act_sel_q, act_sel_d;
    logic [CNT_W-1:0] in_len_q, in_len_d;
    logic [CNT_W-1:0] out_len_q, out_len_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             done_q, done_d;
    logic             err_in_q, err_in_d;
    logic             err_out_q, err_out_d;
    logic [31:0]      prdata_q, prdata_d;

    // APB decode
    logic [2:0]  addr;
    logic [3:0]  wsel;
    logic        setup, access, wr_access, ctrl_wr;
    logic        busy, unmapped;
    logic        start_req, abort_req, start_bad, start_ok;
    logic        slverr;
    logic [31:0] rd_data;

    // Stream datapath
    logic             in_done, out_done, in_last, out_last;
    logic             in_beat, out_beat;
    logic             sel_s_tready, sel_m_tvalid, sel_m_tlast;
    logic [DATA_W-1:0] sel_m_tdata;
    logic             s_tready, m_tvalid, m_tlast;
    logic [NUM_ENG-1:0] eng_s_tvalid, eng_s_tlast, eng_m_tready;
    logic [CNT_W-1:0] in_last_idx, out_last_idx;

    logic unused_bits;
    assign unused_bits = ^{bus.PADDR[31:5], bus.PADDR[1:0], bus.PWDATA};

    assign addr      = bus.PADDR[4:2];
    assign wsel      = bus.PWDATA[7:4];
    assign setup     = bus.PSEL & ~bus.PENABLE;
    assign access    = bus.PSEL & bus.PENABLE;
    assign wr_access = access & bus.PWRITE;
    assign ctrl_wr   = wr_access & (addr == A_CTRL);
    assign busy      = (state_q != ST_IDLE);
    assign unmapped  = addr[2] & addr[1];

    assign start_req = ctrl_wr & bus.PWDATA[0];
    assign abort_req = ctrl_wr & bus.PWDATA[1] & (state_q == ST_RUN);
    assign start_bad = ({28'd0, wsel} >= NUM_ENG) | (in_len_q == '0) | (out_len_q == '0);
    assign start_ok  = start_req & ~busy & ~start_bad;

    // Access-phase error flag. A CTRL write while busy is only clean when
    // it leaves SEL unchanged and does not request START, so ABORT can be
    // issued by rewriting the current SEL with bit1 set.
    always_comb begin
        slverr = 1'b0;
        if (access && unmapped) begin
            slverr = 1'b1;
        end
        if (wr_access && busy && (addr == A_IN_LEN || addr == A_OUT_LEN)) begin
            slverr = 1'b1;
        end
        if (ctrl_wr && busy && (bus.PWDATA[0] || wsel != sel_q)) begin
            slverr = 1'b1;
        end
        if (ctrl_wr && !busy && bus.PWDATA[0] && start_bad) begin
            slverr = 1'b1;
        end
    end

    assign bus.PREADY  = 1'b1;
    assign bus.PSLVERR = slverr;
    assign bus.PRDATA  = prdata_q;

    // Read mux, captured during the setup phase so PRDATA is valid in access
    always_comb begin
        rd_data = 32'd0;
        case (addr)
            A_CTRL:    rd_data = {24'd0, sel_q, 4'd0};
            A_IN_LEN:  rd_data = 32'(in_len_q);
            A_OUT_LEN: rd_data = 32'(out_len_q);
            A_STATUS:  rd_data = {20'd0, act_sel_q, 4'd0, err_out_q, err_in_q, done_q, busy};
            A_IN_CNT:  rd_data = 32'(in_cnt_q);
            A_OUT_CNT: rd_data = 32'(out_cnt_q);
            default:   rd_data = 32'd0;
        endcase
    end

    // Selected-channel forwarding; everything is gated off outside RUN
    always_comb begin
        in_last_idx  = in_len_q - CNT_W'(1);
        out_last_idx = out_len_q - CNT_W'(1);
        in_done      = (in_cnt_q == in_len_q);
        out_done     = (out_cnt_q == out_len_q);
        in_last      = (in_cnt_q == in_last_idx);
        out_last     = (out_cnt_q == out_last_idx);
        sel_s_tready = 1'b0;
        sel_m_tvalid = 1'b0;
        sel_m_tlast  = 1'b0;
        sel_m_tdata  = '0;
        s_tready     = 1'b0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        eng_s_tvalid = '0;
        eng_s_tlast  = '0;
        eng_m_tready = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (act_sel_q == 4'(i)) begin
                sel_s_tready = bus.ENG_S_TREADY[i];
                sel_m_tvalid = bus.ENG_M_TVALID[i];
                sel_m_tlast  = bus.ENG_M_TLAST[i];
                sel_m_tdata  = bus.ENG_M_TDATA[i*DATA_W +: DATA_W];
            end
        end
        if (state_q == ST_RUN) begin
            s_tready = sel_s_tready & ~in_done;
            m_tvalid = sel_m_tvalid & ~out_done;
            m_tlast  = out_last;
            for (int i = 0; i < NUM_ENG; i++) begin
                if (act_sel_q == 4'(i)) begin
                    eng_s_tvalid[i] = bus.S_AXIS_TVALID & ~in_done;
                    eng_s_tlast[i]  = in_last;
                    eng_m_tready[i] = bus.M_AXIS_TREADY & ~out_done;
                end
            end
        end
        in_beat  = bus.S_AXIS_TVALID & s_tready;
        out_beat = m_tvalid & bus.M_AXIS_TREADY;
    end

    assign bus.ENG_S_TDATA   = {NUM_ENG{bus.S_AXIS_TDATA}};
    assign bus.ENG_S_TVALID  = eng_s_tvalid;
    assign bus.ENG_S_TLAST   = eng_s_tlast;
    assign bus.ENG_M_TREADY  = eng_m_tready;
    assign bus.S_AXIS_TREADY = s_tready;
    assign bus.M_AXIS_TVALID = m_tvalid;
    assign bus.M_AXIS_TLAST  = m_tlast;
    assign bus.M_AXIS_TDATA  = sel_m_tdata;

    // Job FSM next state plus register-file, counter and status updates.
    // Status clears are applied before set events so a set wins.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        act_sel_d = act_sel_q;
        in_len_d  = in_len_q;
        out_len_d = out_len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = done_q;
        err_in_d  = err_in_q;
        err_out_d = err_out_q;
        prdata_d  = prdata_q;

        if (setup && !bus.PWRITE) begin
            prdata_d = rd_data;
        end

        if (wr_access && !busy) begin
            case (addr)
                A_CTRL:    sel_d     = wsel;
                A_IN_LEN:  in_len_d  = bus.PWDATA[CNT_W-1:0];
                A_OUT_LEN: out_len_d = bus.PWDATA[CNT_W-1:0];
                default:   ;
            endcase
        end

        if (wr_access && addr == A_STATUS) begin
            done_d    = done_q    & ~bus.PWDATA[1];
            err_in_d  = err_in_q  & ~bus.PWDATA[2];
            err_out_d = err_out_q & ~bus.PWDATA[3];
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d   = ST_RUN;
                    act_sel_d = wsel;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    done_d    = 1'b0;
                    err_in_d  = 1'b0;
                    err_out_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (in_beat) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (bus.S_AXIS_TLAST != in_last) begin
                        err_in_d = 1'b1;
                    end
                end
                if (out_beat) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (sel_m_tlast != out_last) begin
                        err_out_d = 1'b1;
                    end
                end
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (in_done && out_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register flops, cleared asynchronously
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            act_sel_q <= '0;
            in_len_q  <= '0;
            out_len_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
            err_in_q  <= 1'b0;
            err_out_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            act_sel_q <= act_sel_d;
            in_len_q  <= in_len_d;
            out_len_q <= out_len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
            err_in_q  <= err_in_d;
            err_out_q <= err_out_d;
            prdata_q  <= prdata_d;
        end
    end

endmodule

// File: tb/tb_engine_stream_switch.sv
// Testbench for engine_stream_switch: APB register access, scoreboarded
// stream jobs with stalls, error/abort/reset scenarios.
module tb_engine_stream_switch;

    localparam int NUM_ENG = 3;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 20;
    localparam int BUDGET  = 2000;

    localparam logic [31:0] R_CTRL    = 32'h00;
    localparam logic [31:0] R_IN_LEN  = 32'h04;
    localparam logic [31:0] R_OUT_LEN = 32'h08;
    localparam logic [31:0] R_STATUS  = 32'h0C;
    localparam logic [31:0] R_IN_CNT  = 32'h10;
    localparam logic [31:0] R_OUT_CNT = 32'h14;
    localparam logic [31:0] R_BAD     = 32'h18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    engine_stream_switch_if #(.NUM_ENG(NUM_ENG), .DATA_W(DATA_W)) bus ();

    engine_stream_switch #(
        .NUM_ENG(NUM_ENG),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK   (clk),
        .RESETN(rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] in_q[$];
    logic [32:0] out_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_streams();
        bus.S_AXIS_TDATA  = '0;
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TLAST  = 1'b0;
        bus.M_AXIS_TREADY = 1'b0;
        bus.ENG_S_TREADY  = '0;
        bus.ENG_M_TDATA   = '0;
        bus.ENG_M_TVALID  = '0;
        bus.ENG_M_TLAST   = '0;
    endtask

    task automatic idle_all();
        bus.PADDR   = '0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PWDATA  = '0;
        idle_streams();
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic exp_err, input string tag);
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        bus.PWRITE  = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        #3;
        check_val({tag, "_slverr"}, 32'(bus.PSLVERR), 32'(exp_err));
        step();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic exp_err, input string tag,
                            output logic [31:0] data);
        bus.PADDR   = addr;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        #3;
        data = bus.PRDATA;
        check_val({tag, "_slverr"}, 32'(bus.PSLVERR), 32'(exp_err));
        step();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic read_expect(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        apb_read(addr, 1'b0, tag, rd);
        check_val(tag, rd, exp);
    endtask

    // Drives one job: n_in input beats, n_out engine output beats on channel
    // sel. Expected beats are queued when offered and checked on arrival.
    // bad_last >= 0 puts S_AXIS_TLAST on that beat index only.
    task automatic run_job(input int sel, input int in_len, input int out_len,
                           input int n_in, input int n_out, input int stall, input int bad_last,
                           input logic [31:0] in_base, input logic [31:0] out_base);
        int in_off = 0, out_off = 0, in_acc = 0, out_acc = 0, cyc = 0, viol = 0;
        logic s_v = 1'b0, s_last = 1'b0, e_v = 1'b0, e_last = 1'b0;
        logic [31:0] s_d = '0, e_d = '0;
        logic [32:0] exp_b;
        in_q.delete();
        out_q.delete();
        while ((in_acc < n_in || out_acc < n_out) && cyc < BUDGET) begin
            if (!s_v && in_off < n_in && $urandom_range(99) >= stall) begin
                s_v    = 1'b1;
                s_d    = in_base + 32'(in_off);
                s_last = (bad_last >= 0) ? (in_off == bad_last) : (in_off == in_len - 1);
                in_q.push_back({(in_off == in_len - 1), s_d});
                in_off++;
            end else if (!s_v && in_off == in_len && n_in == in_len) begin
                s_v    = 1'b1;
                s_d    = 32'hDEAD_BEEF;
                s_last = 1'b1;
            end
            if (!e_v && out_off < n_out && $urandom_range(99) >= stall) begin
                e_v    = 1'b1;
                e_d    = out_base + 32'(out_off);
                e_last = (out_off == out_len - 1);
                out_q.push_back({e_last, e_d});
                out_off++;
            end
            bus.S_AXIS_TVALID = s_v;
            bus.S_AXIS_TDATA  = s_d;
            bus.S_AXIS_TLAST  = s_last;
            bus.M_AXIS_TREADY = ($urandom_range(99) >= stall);
            for (int i = 0; i < NUM_ENG; i++) begin
                bus.ENG_S_TREADY[i] = ($urandom_range(99) >= stall);
                if (i == sel) begin
                    bus.ENG_M_TVALID[i] = e_v;
                    bus.ENG_M_TLAST[i]  = e_last;
                    bus.ENG_M_TDATA[i*DATA_W +: DATA_W] = e_d;
                end else begin
                    bus.ENG_M_TVALID[i] = 1'($urandom_range(1));
                    bus.ENG_M_TLAST[i]  = 1'($urandom_range(1));
                    bus.ENG_M_TDATA[i*DATA_W +: DATA_W] = $urandom;
                end
            end
            #4;
            if (in_acc == in_len && bus.S_AXIS_TREADY) viol++;
            if ((bus.S_AXIS_TVALID & bus.S_AXIS_TREADY) !=
                (bus.ENG_S_TVALID[sel] & bus.ENG_S_TREADY[sel])) viol++;
            if (bus.ENG_S_TVALID[sel] && bus.ENG_S_TREADY[sel]) begin
                if (in_q.size() == 0) begin
                    check_val("in_extra_beat", 32'd1, 32'd0);
                end else begin
                    exp_b = in_q.pop_front();
                    check_val("eng_in_data", bus.ENG_S_TDATA[sel*DATA_W +: DATA_W], exp_b[31:0]);
                    check_val("eng_in_last", 32'(bus.ENG_S_TLAST[sel]), 32'(exp_b[32]));
                    in_acc++;
                end
            end
            if (bus.S_AXIS_TVALID && bus.S_AXIS_TREADY) s_v = 1'b0;
            if ((bus.ENG_M_TVALID[sel] & bus.ENG_M_TREADY[sel]) !=
                (bus.M_AXIS_TVALID & bus.M_AXIS_TREADY)) viol++;
            if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
                if (out_q.size() == 0) begin
                    check_val("out_extra_beat", 32'd1, 32'd0);
                end else begin
                    exp_b = out_q.pop_front();
                    check_val("m_axis_data", bus.M_AXIS_TDATA, exp_b[31:0]);
                    check_val("m_axis_last", 32'(bus.M_AXIS_TLAST), 32'(exp_b[32]));
                    out_acc++;
                end
            end
            if (bus.ENG_M_TVALID[sel] && bus.ENG_M_TREADY[sel]) e_v = 1'b0;
            for (int i = 0; i < NUM_ENG; i++) begin
                if (i != sel && (bus.ENG_S_TVALID[i] || bus.ENG_S_TLAST[i] || bus.ENG_M_TREADY[i])) viol++;
                if (bus.ENG_S_TDATA[i*DATA_W +: DATA_W] !== bus.S_AXIS_TDATA) viol++;
            end
            step();
            cyc++;
        end
        check_val("job_in_beats", 32'(in_acc), 32'(n_in));
        check_val("job_out_beats", 32'(out_acc), 32'(n_out));
        check_val("job_handshake_viol", 32'(viol), 32'd0);
        idle_streams();
    endtask

    // Safety net in case a wait ever stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_prdata",  bus.PRDATA, 32'd0);
        check_val("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        check_val("rst_pready",  32'(bus.PREADY), 32'd1);
        check_val("rst_s_tready", 32'(bus.S_AXIS_TREADY), 32'd0);
        check_val("rst_m_tvalid", 32'(bus.M_AXIS_TVALID), 32'd0);
        check_val("rst_m_tlast",  32'(bus.M_AXIS_TLAST), 32'd0);
        check_val("rst_eng_s_tvalid", 32'(bus.ENG_S_TVALID), 32'd0);
        check_val("rst_eng_m_tready", 32'(bus.ENG_M_TREADY), 32'd0);
        rst_n = 1'b1;
        step();
        read_expect(R_STATUS, 32'h0, "rst_status");

        // Basic job on channel 1
        apb_write(R_IN_LEN, 32'd4, 1'b0, "t1_in_len");
        apb_write(R_OUT_LEN, 32'd2, 1'b0, "t1_out_len");
        apb_write(R_CTRL, 32'h11, 1'b0, "t1_start");
        run_job(1, 4, 2, 4, 2, 0, -1, 32'hA0, 32'hB0);
        repeat (3) step();
        read_expect(R_STATUS, 32'h102, "t1_status");
        read_expect(R_IN_CNT, 32'd4, "t1_in_cnt");
        read_expect(R_OUT_CNT, 32'd2, "t1_out_cnt");
        read_expect(R_CTRL, 32'h10, "t1_ctrl_sel");

        // Random stalls on every side, channel 2
        apb_write(R_IN_LEN, 32'd16, 1'b0, "t2_in_len");
        apb_write(R_OUT_LEN, 32'd16, 1'b0, "t2_out_len");
        apb_write(R_CTRL, 32'h21, 1'b0, "t2_start");
        run_job(2, 16, 16, 16, 16, 50, -1, 32'h1000, 32'h2000);
        repeat (3) step();
        read_expect(R_STATUS, 32'h202, "t2_status");
        read_expect(R_IN_CNT, 32'd16, "t2_in_cnt");
        read_expect(R_OUT_CNT, 32'd16, "t2_out_cnt");

        // Rejected STARTs and unmapped address
        apb_write(R_CTRL, 32'h31, 1'b1, "t3_start_sel3");
        apb_read(R_STATUS, 1'b0, "t3_status_a", rd);
        check_val("t3_busy_after_sel3", 32'(rd[0]), 32'd0);
        apb_write(R_IN_LEN, 32'd0, 1'b0, "t3_in_len0");
        apb_write(R_CTRL, 32'h01, 1'b1, "t3_start_len0");
        apb_read(R_STATUS, 1'b0, "t3_status_b", rd);
        check_val("t3_busy_after_len0", 32'(rd[0]), 32'd0);
        apb_write(R_BAD, 32'h5, 1'b1, "t3_wr_unmapped");
        apb_read(R_BAD, 1'b1, "t3_rd_unmapped", rd);

        // Input TLAST error on beat 2 of 4, then W1C of err_in_last
        apb_write(R_IN_LEN, 32'd4, 1'b0, "t4_in_len");
        apb_write(R_OUT_LEN, 32'd1, 1'b0, "t4_out_len");
        apb_write(R_CTRL, 32'h01, 1'b0, "t4_start");
        run_job(0, 4, 1, 4, 1, 0, 1, 32'h300, 32'h400);
        repeat (3) step();
        read_expect(R_STATUS, 32'h006, "t4_status_err");
        apb_write(R_STATUS, 32'h4, 1'b0, "t4_w1c");
        read_expect(R_STATUS, 32'h002, "t4_status_cleared");

        // Abort after 3 of 8 input beats, then a clean job on channel 0
        apb_write(R_IN_LEN, 32'd8, 1'b0, "t5_in_len");
        apb_write(R_OUT_LEN, 32'd8, 1'b0, "t5_out_len");
        apb_write(R_CTRL, 32'h21, 1'b0, "t5_start");
        read_expect(R_STATUS, 32'h201, "t5_status_busy");
        apb_write(R_IN_LEN, 32'd5, 1'b1, "t5_len_while_busy");
        apb_write(R_CTRL, 32'h31, 1'b1, "t5_start_while_busy");
        run_job(2, 8, 8, 3, 0, 0, -1, 32'h500, 32'h600);
        apb_write(R_CTRL, 32'h22, 1'b0, "t5_abort");
        bus.S_AXIS_TVALID = 1'b1;
        bus.ENG_S_TREADY  = '1;
        #1;
        check_val("t5_s_tready_after_abort", 32'(bus.S_AXIS_TREADY), 32'd0);
        check_val("t5_eng_s_tvalid_after_abort", 32'(bus.ENG_S_TVALID), 32'd0);
        idle_streams();
        step();
        read_expect(R_STATUS, 32'h200, "t5_status_aborted");
        read_expect(R_IN_CNT, 32'd3, "t5_in_cnt");
        read_expect(R_IN_LEN, 32'd8, "t5_in_len_kept");
        apb_write(R_IN_LEN, 32'd2, 1'b0, "t5b_in_len");
        apb_write(R_OUT_LEN, 32'd2, 1'b0, "t5b_out_len");
        apb_write(R_CTRL, 32'h01, 1'b0, "t5b_start");
        run_job(0, 2, 2, 2, 2, 30, -1, 32'h700, 32'h800);
        repeat (3) step();
        read_expect(R_STATUS, 32'h002, "t5b_status");

        // Reset in the middle of a job
        apb_write(R_IN_LEN, 32'd8, 1'b0, "t6_in_len");
        apb_write(R_OUT_LEN, 32'd8, 1'b0, "t6_out_len");
        apb_write(R_CTRL, 32'h11, 1'b0, "t6_start");
        run_job(1, 8, 8, 2, 0, 0, -1, 32'h900, 32'hA00);
        bus.S_AXIS_TVALID = 1'b1;
        bus.ENG_S_TREADY  = '1;
        bus.ENG_M_TVALID  = '1;
        bus.M_AXIS_TREADY = 1'b1;
        #1;
        check_val("t6_pre_s_tready", 32'(bus.S_AXIS_TREADY), 32'd1);
        check_val("t6_pre_m_tvalid", 32'(bus.M_AXIS_TVALID), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_s_tready", 32'(bus.S_AXIS_TREADY), 32'd0);
        check_val("t6_rst_m_tvalid", 32'(bus.M_AXIS_TVALID), 32'd0);
        check_val("t6_rst_eng_s_tvalid", 32'(bus.ENG_S_TVALID), 32'd0);
        check_val("t6_rst_eng_m_tready", 32'(bus.ENG_M_TREADY), 32'd0);
        check_val("t6_rst_m_tlast", 32'(bus.M_AXIS_TLAST), 32'd0);
        idle_streams();
        step();
        step();
        rst_n = 1'b1;
        step();
        read_expect(R_STATUS, 32'h0, "t6_status_after_reset");
        read_expect(R_IN_CNT, 32'h0, "t6_in_cnt_after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
